// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and default widths for the pipeline stage buffer.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

  localparam int c_ctrl_w   = 10;
  localparam int c_scalar_w = 19;
  localparam int c_lanes    = 16;
  localparam int c_lane_w   = 16;
  localparam int c_reg_w    = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  typedef logic [c_lanes-1:0][c_lane_w-1:0] vec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf_if
// Brief    : Valid/ready payload bus between pipeline stages.
// Revision : 1.0
// ============================================================================
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = c_ctrl_w,
  parameter int SCALAR_W = c_scalar_w,
  parameter int LANES    = c_lanes,
  parameter int LANE_W   = c_lane_w,
  parameter int REG_W    = c_reg_w
) ();

  logic                             valid;
  logic                             ready;
  logic [CTRL_W-1:0]                ctrl;
  logic [SCALAR_W-1:0]              sa;
  logic [SCALAR_W-1:0]              sb;
  logic [LANES-1:0][LANE_W-1:0]     va;
  logic [LANES-1:0][LANE_W-1:0]     vb;
  logic [REG_W-1:0]                 rd;

  modport master (output valid, ctrl, sa, sb, va, vb, rd, input ready);
  modport slave  (input valid, ctrl, sa, sb, va, vb, rd, output ready);

endinterface
`default_nettype wire

// File: rtl/pipe_stage_buf_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry
// Brief    : One payload slot with load, synchronous clear and async reset.
// Revision : 1.0
// ============================================================================
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = c_ctrl_w,
  parameter int SCALAR_W = c_scalar_w,
  parameter int LANES    = c_lanes,
  parameter int LANE_W   = c_lane_w,
  parameter int REG_W    = c_reg_w
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_load,
  input  wire logic                         i_clear,
  input  wire logic [CTRL_W-1:0]            i_ctrl,
  input  wire logic [SCALAR_W-1:0]          i_sa,
  input  wire logic [SCALAR_W-1:0]          i_sb,
  input  wire logic [LANES-1:0][LANE_W-1:0] i_va,
  input  wire logic [LANES-1:0][LANE_W-1:0] i_vb,
  input  wire logic [REG_W-1:0]             i_rd,
  output logic      [CTRL_W-1:0]            o_ctrl,
  output logic      [SCALAR_W-1:0]          o_sa,
  output logic      [SCALAR_W-1:0]          o_sb,
  output logic      [LANES-1:0][LANE_W-1:0] o_va,
  output logic      [LANES-1:0][LANE_W-1:0] o_vb,
  output logic      [REG_W-1:0]             o_rd
);

  logic [CTRL_W-1:0]            r_ctrl;
  logic [SCALAR_W-1:0]          r_sa;
  logic [SCALAR_W-1:0]          r_sb;
  logic [LANES-1:0][LANE_W-1:0] r_va;
  logic [LANES-1:0][LANE_W-1:0] r_vb;
  logic [REG_W-1:0]             r_rd;

  // Clear wins over load so a flush also discards a coincident transfer.
  always_ff @(negedge clk or posedge rst) begin
    if (rst || i_clear) begin
      r_ctrl <= '0;
      r_sa   <= '0;
      r_sb   <= '0;
      r_va   <= '0;
      r_vb   <= '0;
      r_rd   <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_sa   <= i_sa;
      r_sb   <= i_sb;
      r_va   <= i_va;
      r_vb   <= i_vb;
      r_rd   <= i_rd;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_sa   = r_sa;
  assign o_sb   = r_sb;
  assign o_va   = r_va;
  assign o_vb   = r_vb;
  assign o_rd   = r_rd;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Flow-controlled stage register with 2-entry skid and flush.
//            Define PIPE_BUF_STATS_EN to add stall/flush counters.
// Revision : 1.0
// ============================================================================
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = c_ctrl_w,
  parameter int SCALAR_W = c_scalar_w,
  parameter int LANES    = c_lanes,
  parameter int LANE_W   = c_lane_w,
  parameter int REG_W    = c_reg_w
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  pipe_stage_buf_if.slave       up,
  pipe_stage_buf_if.master      dn
`ifdef PIPE_BUF_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  buf_state_t r_state;
  buf_state_t w_state_nxt;
  logic       w_load_main;
  logic       w_load_skid;
  logic       w_main_from_skid;
  logic       w_out_valid;

  logic [CTRL_W-1:0]            w_main_ctrl, w_skid_ctrl, w_main_d_ctrl;
  logic [SCALAR_W-1:0]          w_skid_sa, w_skid_sb, w_main_d_sa, w_main_d_sb;
  logic [LANES-1:0][LANE_W-1:0] w_skid_va, w_skid_vb, w_main_d_va, w_main_d_vb;
  logic [REG_W-1:0]             w_skid_rd, w_main_d_rd;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (up.valid) begin
          w_load_main = 1'b1;
          w_state_nxt = ONE;
        end
        ONE: begin
          if (up.valid && dn.ready) begin
            w_load_main = 1'b1;
          end else if (up.valid) begin
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end else if (dn.ready) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: if (dn.ready) begin
          w_load_main = 1'b1;
          w_state_nxt = ONE;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // In FULL the main slot refills from the skid; otherwise straight from upstream.
  assign w_main_from_skid = (r_state == FULL);
  assign w_main_d_ctrl    = w_main_from_skid ? w_skid_ctrl : up.ctrl;
  assign w_main_d_sa      = w_main_from_skid ? w_skid_sa   : up.sa;
  assign w_main_d_sb      = w_main_from_skid ? w_skid_sb   : up.sb;
  assign w_main_d_va      = w_main_from_skid ? w_skid_va   : up.va;
  assign w_main_d_vb      = w_main_from_skid ? w_skid_vb   : up.vb;
  assign w_main_d_rd      = w_main_from_skid ? w_skid_rd   : up.rd;

  pipe_entry #(
    .CTRL_W(CTRL_W), .SCALAR_W(SCALAR_W), .LANES(LANES), .LANE_W(LANE_W), .REG_W(REG_W)
  ) u_main (
    .clk(clk), .rst(rst), .i_load(w_load_main), .i_clear(flush),
    .i_ctrl(w_main_d_ctrl), .i_sa(w_main_d_sa), .i_sb(w_main_d_sb),
    .i_va(w_main_d_va), .i_vb(w_main_d_vb), .i_rd(w_main_d_rd),
    .o_ctrl(w_main_ctrl), .o_sa(dn.sa), .o_sb(dn.sb),
    .o_va(dn.va), .o_vb(dn.vb), .o_rd(dn.rd)
  );

  pipe_entry #(
    .CTRL_W(CTRL_W), .SCALAR_W(SCALAR_W), .LANES(LANES), .LANE_W(LANE_W), .REG_W(REG_W)
  ) u_skid (
    .clk(clk), .rst(rst), .i_load(w_load_skid), .i_clear(flush),
    .i_ctrl(up.ctrl), .i_sa(up.sa), .i_sb(up.sb),
    .i_va(up.va), .i_vb(up.vb), .i_rd(up.rd),
    .o_ctrl(w_skid_ctrl), .o_sa(w_skid_sa), .o_sb(w_skid_sb),
    .o_va(w_skid_va), .o_vb(w_skid_vb), .o_rd(w_skid_rd)
  );

  assign w_out_valid = (r_state != EMPTY);
  assign dn.valid    = w_out_valid;
  assign up.ready    = (r_state != FULL);
  assign dn.ctrl     = w_main_ctrl & {CTRL_W{w_out_valid}};

`ifdef PIPE_BUF_STATS_EN
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (w_out_valid && !dn.ready)       stall_cnt <= sat_inc16(stall_cnt);
      if (flush && (r_state != EMPTY))    flush_cnt <= sat_inc16(flush_cnt);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Brief    : Directed self-checking bench for pipe_stage_buf.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_stage_buf_if up ();
  pipe_stage_buf_if dn ();

`ifdef PIPE_BUF_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  pipe_stage_buf dut (
    .clk(clk), .rst(rst), .flush(flush), .up(up), .dn(dn)
`ifdef PIPE_BUF_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the rising edge, then sample just after the capturing falling edge.
  task automatic drive(input logic v, input logic ordy, input logic fl,
                       input logic [9:0] ctrl, input logic [18:0] sa, input logic [4:0] rd);
    vec_t va;
    @(posedge clk);
    va = {16{sa[15:0]}};
    up.valid = v;
    dn.ready = ordy;
    flush    = fl;
    up.ctrl  = ctrl;
    up.sa    = sa;
    up.sb    = sa + 19'd1;
    up.va    = va;
    up.vb    = '0;
    up.rd    = rd;
    @(negedge clk);
    #1;
  endtask

  initial begin
    up.valid = 1'b0; up.ctrl = '0; up.sa = '0; up.sb = '0;
    up.va = '0; up.vb = '0; up.rd = '0; dn.ready = 1'b1;
    #1;
    chk("rst_out_valid", dn.valid, 1'b0);
    chk("rst_in_ready", up.ready, 1'b1);
    chk("rst_out_sa", dn.sa, 19'd0);
    chk("rst_out_ctrl", dn.ctrl, 10'd0);
    chk("rst_out_va", dn.va, 256'd0);
    @(posedge clk);
    rst = 1'b0;

    // Back-to-back stream with downstream always ready
    drive(1, 1, 0, 10'h155, 19'd1, 5'd1);
    chk("b2b1_sa", dn.sa, 19'd1);
    chk("b2b1_valid", dn.valid, 1'b1);
    chk("b2b1_ready", up.ready, 1'b1);
    chk("b2b1_ctrl", dn.ctrl, 10'h155);
    drive(1, 1, 0, 10'h155, 19'd2, 5'd2);
    chk("b2b2_sa", dn.sa, 19'd2);
    chk("b2b2_valid", dn.valid, 1'b1);
    chk("b2b2_ready", up.ready, 1'b1);
    chk("b2b2_sb", dn.sb, 19'd3);
    drive(1, 1, 0, 10'h155, 19'd3, 5'd3);
    chk("b2b3_sa", dn.sa, 19'd3);
    chk("b2b3_valid", dn.valid, 1'b1);
    chk("b2b3_va", dn.va, {16{16'h0003}});
    drive(0, 1, 0, 10'h155, 19'd0, 5'd0);
    chk("drain_valid", dn.valid, 1'b0);
    chk("drain_ctrl", dn.ctrl, 10'd0);
    chk("drain_hold_sa", dn.sa, 19'd3);

    // Back-pressure into the skid, then release
    drive(1, 0, 0, 10'h0F0, 19'd40, 5'd4);
    chk("stall1_rd", dn.rd, 5'd4);
    chk("stall1_ready", up.ready, 1'b1);
    drive(1, 0, 0, 10'h00F, 19'd70, 5'd7);
    chk("full_ready", up.ready, 1'b0);
    chk("full_rd", dn.rd, 5'd4);
    chk("full_valid", dn.valid, 1'b1);
    drive(0, 0, 0, 10'h000, 19'd0, 5'd0);
    chk("hold_rd", dn.rd, 5'd4);
    chk("hold_ready", up.ready, 1'b0);
    drive(0, 1, 0, 10'h000, 19'd0, 5'd0);
    chk("unskid_rd", dn.rd, 5'd7);
    chk("unskid_sa", dn.sa, 19'd70);
    chk("unskid_ctrl", dn.ctrl, 10'h00F);
    chk("unskid_ready", up.ready, 1'b1);
    drive(0, 1, 0, 10'h000, 19'd0, 5'd0);
    chk("unskid_empty", dn.valid, 1'b0);
`ifdef PIPE_BUF_STATS_EN
    chk("stall_cnt_2", stall_cnt, 16'd2);
`endif

    // Flush while FULL with a coincident input
    drive(1, 0, 0, 10'h3FF, 19'h11, 5'd2);
    drive(1, 0, 0, 10'h3FF, 19'h22, 5'd3);
    chk("pre_flush_ready", up.ready, 1'b0);
    drive(1, 0, 1, 10'h3FF, 19'h33, 5'd5);
    chk("flush_valid", dn.valid, 1'b0);
    chk("flush_ctrl", dn.ctrl, 10'd0);
    chk("flush_ready", up.ready, 1'b1);
    chk("flush_sa", dn.sa, 19'd0);
    chk("flush_rd", dn.rd, 5'd0);
`ifdef PIPE_BUF_STATS_EN
    chk("flush_cnt_1", flush_cnt, 16'd1);
    chk("stall_cnt_4", stall_cnt, 16'd4);
`endif
    drive(0, 1, 0, 10'h000, 19'd0, 5'd0);
    chk("post_flush_valid", dn.valid, 1'b0);
    chk("post_flush_sa", dn.sa, 19'd0);

    // Control gating while EMPTY
    drive(0, 1, 0, 10'h3FF, 19'h7, 5'd9);
    chk("empty_ctrl", dn.ctrl, 10'd0);
    chk("empty_valid", dn.valid, 1'b0);

    // Asynchronous reset between edges while FULL
    drive(1, 0, 0, 10'h2AA, 19'h44, 5'd6);
    drive(1, 0, 0, 10'h2AA, 19'h55, 5'd8);
    chk("pre_rst_ready", up.ready, 1'b0);
    #2;
    rst = 1'b1;
    up.valid = 1'b0;
    #1;
    chk("arst_valid", dn.valid, 1'b0);
    chk("arst_ready", up.ready, 1'b1);
    chk("arst_sa", dn.sa, 19'd0);
    chk("arst_rd", dn.rd, 5'd0);
    chk("arst_ctrl", dn.ctrl, 10'd0);
`ifdef PIPE_BUF_STATS_EN
    chk("arst_stall_cnt", stall_cnt, 16'd0);
    chk("arst_flush_cnt", flush_cnt, 16'd0);
`endif
    @(posedge clk);
    rst = 1'b0;

    drive(1, 1, 0, 10'h001, 19'd5, 5'd1);
    chk("post_rst_sa", dn.sa, 19'd5);
    chk("post_rst_valid", dn.valid, 1'b1);

`ifdef PIPE_BUF_STATS_EN
    drive(0, 0, 0, 10'h000, 19'd0, 5'd0);
    chk("sat_start", stall_cnt, 16'd1);
    repeat (70000) @(negedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised, flow-controlled pipeline stage register for the scalar/vector core. It generalises the fixed inter-stage latches into one block with configurable control, scalar, vector-lane and register-index widths. It adds a valid/ready handshake, a two-entry skid buffer and synchronous flush for bubble insertion. It is instantiated between any two stages (ID/EX, EX/MEM, MEM/WB) so that back-pressure from a slow stage stalls upstream without dropping data.

## Interface
Parameters:
- CTRL_W, 10, number of single-bit control flags carried (MemToReg, RegWrite*, Enable*, ...)
- SCALAR_W, 19, scalar datapath width
- LANES, 16, vector lane count
- LANE_W, 16, bits per vector lane
- REG_W, 5, destination register index width

Ports:
- clk  in  1  stage clock; all state captured on the falling edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  block can accept a payload this cycle
- in_ctrl  in  CTRL_W  control flags
- in_sa, in_sb  in  SCALAR_W  scalar operands (ALU result, store data)
- in_va, in_vb  in  LANES×LANE_W  vector operands, packed [LANES-1:0][LANE_W-1:0]
- in_rd  in  REG_W  destination register index
- out_valid  out  1  output payload valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl, out_sa, out_sb, out_va, out_vb, out_rd  out  as inputs  held payload
- stall_cnt, flush_cnt  out  16  statistics (only with PIPE_BUF_STATS_EN)

## Operation
- Storage: main entry drives the outputs; skid entry absorbs one extra payload when downstream stalls.
- State machine: EMPTY, ONE, FULL.
  - EMPTY: in_valid → load main, go ONE.
  - ONE with in_valid & out_ready: main replaced by the new payload, stay ONE.
  - ONE with in_valid & !out_ready: load skid, go FULL.
  - ONE with !in_valid & out_ready: go EMPTY.
  - FULL with out_ready: main ← skid, go ONE.
  - FULL with !out_ready: hold.
  - in_valid is ignored in FULL, because in_ready = 0.
- Handshake status:
  - in_ready = (state != FULL). It depends on registered state only, with no combinational in→out ready path.
  - out_valid = (state != EMPTY).
- Transfers:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - Upstream must hold its payload stable while in_valid & !in_ready.
- Bubble gating:
  - out_ctrl = main ctrl AND out_valid, so no write/enable flag reaches downstream in EMPTY.
  - Data outputs hold the last value.
- Flush:
  - Highest priority: state → EMPTY and both entries' fields zeroed at the same edge.
  - A coincident input transfer is discarded.
- Reset:
  - Asynchronous; state EMPTY, all entry fields 0.
  - Resulting outputs: out_valid 0, in_ready 1, every out_* bus 0, counters 0.
  - Reset mid-FULL discards both payloads.

## Timing
- Latency is 1 falling edge from input transfer to out_valid in EMPTY/ONE. Through the skid it is 1 extra edge per stalled cycle.
- Throughput is one payload per cycle with out_ready held high.
- in_ready falls the edge after entering FULL. It rises the edge after the first out_ready in FULL.
- Flush takes effect at the next falling edge; out_valid is 0 immediately after.

## Configuration
- PIPE_BUF_STATS_EN defined:
  - stall_cnt increments each edge where out_valid & !out_ready.
  - flush_cnt increments each edge where flush = 1 and state != EMPTY.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on rst only.
- Not defined: stall_cnt/flush_cnt ports are absent and no counter logic is generated.

## Structure
- pipe_pkg:
  - state enum buf_state_t {EMPTY, ONE, FULL}
  - default width localparams
  - typedef vec_t for the packed lane array
- Sub-module pipe_entry:
  - one payload slot with load, clear and async reset
  - instantiated twice (main, skid)

## Test plan
- Reset, then release, out_ready=1, three back-to-back inputs (in_sa = 1, 2, 3) → out_sa 1, 2, 3 on consecutive edges, out_valid continuous, in_ready always 1.
- out_ready=0 with two inputs (in_rd = 4, 7) → FULL, in_ready=0; then out_ready=1 → out_rd 4 then 7, nothing lost or duplicated.
- FULL, flush=1 with in_valid=1 → next edge out_valid=0, out_ctrl=0, in_ready=1; the flushed payloads never appear.
- EMPTY with in_ctrl=10'h3FF, in_valid=0 → out_ctrl stays 0.
- rst asserted asynchronously mid-FULL between edges → outputs 0 and in_ready=1 immediately; with stats enabled, stall_cnt reads 0.
- Stats enabled, out_valid=1 with out_ready=0 for 70000 edges → stall_cnt saturates at 16'hFFFF.
